// File: rtl/talanquera_actuator.sv
`default_nettype none
// ============================================================================
// Module  : talanquera_actuator
// Brief   : Barrier motor driver: sensor debounce, travel/dead-time FSM, status.
// Revision: 1.0 - initial release
// ============================================================================
module talanquera_actuator #(
  parameter int DEB_CYC    = 16,
  parameter int TRAVEL_MAX = 50_000_000,
  parameter int DEAD_CYC   = 1_000_000
) (
  input  logic       clk,
  input  logic       R,
  input  logic [1:0] TAL,
  input  logic       LIM_UP,
  input  logic       LIM_DN,
  input  logic       OBS,
  output logic       MOT_UP,
  output logic       MOT_DN,
  output logic [1:0] POS,
  output logic       FAULT
);

  localparam int c_cnt_max = (TRAVEL_MAX > DEAD_CYC) ? TRAVEL_MAX : DEAD_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_deb_w   = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    S_CLOSING  = 3'd0,
    S_CLOSED   = 3'd1,
    S_OPENING  = 3'd2,
    S_OPEN     = 3'd3,
    S_REV_WAIT = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Bit order of sensor vectors: {obstacle, lower limit, upper limit}
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] deb_w;

  always_comb begin
    sync1_d = {OBS, LIM_DN, LIM_UP};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [c_deb_w-1:0] cnt_q, cnt_d;
    logic               deb_q, deb_d;

    // Counter tracks consecutive disagreeing samples; any agreeing sample restarts it.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q[i] != deb_q) begin
        if (cnt_q == c_deb_w'(DEB_CYC - 1)) begin
          deb_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + c_deb_w'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (R) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb_w[i] = deb_q;
  end

  logic lu, ld, ob, tal_up;
  assign lu     = deb_w[0];
  assign ld     = deb_w[1];
  assign ob     = deb_w[2];
  assign tal_up = (TAL == 2'b01) || (TAL == 2'b10);

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               tgt_open_q, tgt_open_d;

  always_comb begin
    state_d    = state_q;
    tgt_open_d = tgt_open_q;
    MOT_UP     = 1'b0;
    MOT_DN     = 1'b0;
    POS        = 2'b00;
    FAULT      = 1'b0;
    case (state_q)
      S_CLOSING: begin
        MOT_DN = 1'b1;
        POS    = 2'b11;
        if (ob || tal_up) begin
          state_d    = S_REV_WAIT;
          tgt_open_d = 1'b1;
        end else if (ld) begin
          state_d = S_CLOSED;
        end else if (cnt_q == c_cnt_w'(TRAVEL_MAX - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_CLOSED: begin
        if (tal_up) begin
          state_d = S_OPENING;
        end else if (!ld) begin
          state_d = S_CLOSING;
        end
      end
      S_OPENING: begin
        MOT_UP = 1'b1;
        POS    = 2'b01;
        if (lu) begin
          state_d = S_OPEN;
        end else if (cnt_q == c_cnt_w'(TRAVEL_MAX - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_OPEN: begin
        POS = 2'b10;
        if (!tal_up && !ob) begin
          state_d    = S_REV_WAIT;
          tgt_open_d = 1'b0;
        end
      end
      S_REV_WAIT: begin
        POS = 2'b11;
        if (cnt_q == c_cnt_w'(DEAD_CYC - 1)) begin
          if (tgt_open_q) begin
            state_d = S_OPENING;
          end else begin
            // Never start lowering onto something that appeared during the dead time
            state_d = ob ? S_OPEN : S_CLOSING;
          end
        end
      end
      S_FAULT: begin
        FAULT = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    if (lu && ld) begin
      state_d = S_FAULT;
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_w'(c_cnt_max)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= S_CLOSING;
      cnt_q      <= '0;
      tgt_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_open_q <= tgt_open_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/talanquera_actuator.md
Name: talanquera_actuator

Overview:
Physical-side driver for the parking barrier. It consumes the 2-bit barrier command TAL produced by the entry-control FSM (DOWN=00, UP_START=01, UP=10, DOWN_START=11) and drives the barrier motor (up/down) from debounced limit switches and an obstacle sensor. It also enforces a travel timeout, a reversal dead time and obstacle reversal, and reports position and fault status to the Basys3 LEDs.

Parameters:
DEB_CYC, 16, consecutive identical samples required to change a debounced sensor value (>=1)
TRAVEL_MAX, 50_000_000, max cycles in OPENING or CLOSING before FAULT
DEAD_CYC, 1_000_000, cycles with both motor outputs low when reversing direction (>=1)

Ports:
clk  in  1  system clock
R  in  1  reset, synchronous, active-high
TAL  in  2  barrier command: 00 DOWN, 01 UP_START, 10 UP, 11 DOWN_START
LIM_UP  in  1  raw upper limit switch, 1 = barrier fully up
LIM_DN  in  1  raw lower limit switch, 1 = barrier fully down
OBS  in  1  raw obstacle/loop sensor under the arm, 1 = obstructed
MOT_UP  out  1  motor drive, raise
MOT_DN  out  1  motor drive, lower
POS  out  2  status: 00 closed, 01 moving up, 10 open, 11 moving down / dead time
FAULT  out  1  latched fault indicator

Behaviour:
- Debounce: LIM_UP, LIM_DN and OBS each pass through a 2-flop synchroniser and then a per-signal counter. The debounced value changes only after DEB_CYC consecutive synchronised samples differ from it. Debounced values reset to 0. All FSM decisions use the debounced values (lu, ld, ob). TAL is used directly, without debounce.
- Outputs are a Moore decode of the current state. MOT_UP and MOT_DN are never both 1.
- One travel/dead counter is cleared on every state entry and increments while the state is held.
- States and transitions are evaluated every clk. Priority is listed top-down within each state.
- In every state, lu & ld both 1 -> FAULT.
- CLOSING: MOT_DN=1, POS=11.
  - ob -> REV_WAIT (target OPENING).
  - TAL in {UP_START, UP} -> REV_WAIT (target OPENING).
  - ld -> CLOSED.
  - counter == TRAVEL_MAX-1 -> FAULT.
- CLOSED: motors 0, POS=00.
  - TAL in {UP_START, UP} -> OPENING.
  - ld falls to 0 (arm pushed up) -> CLOSING.
- OPENING: MOT_UP=1, POS=01.
  - lu -> OPEN.
  - counter == TRAVEL_MAX-1 -> FAULT.
  - TAL is ignored; an opening always completes.
- OPEN: motors 0, POS=10.
  - TAL in {DOWN_START, DOWN} and ob=0 -> REV_WAIT (target CLOSING).
  - If ob=1, hold OPEN.
- REV_WAIT: motors 0, POS=11. After DEAD_CYC cycles in the state -> target state. The target is held in a 1-bit register.
  - Exception: if the target is CLOSING and ob=1 at expiry, go to OPEN instead (never lower onto an obstacle).
- FAULT: motors 0, POS=00, FAULT=1. Exit only via R.
- Reset (R=1 at clk edge, including mid-travel):
  - state -> CLOSING (homing descent); counter, debouncers, synchronisers and target cleared.
  - In the cycle after reset: MOT_DN=1, MOT_UP=0, POS=11, FAULT=0.
  - The homing descent obeys all CLOSING rules.
- Simultaneous events: the order given above decides. Examples: ob and ld together in CLOSING -> REV_WAIT; lu and timeout together in OPENING -> OPEN.
- The counter width is sized for max(TRAVEL_MAX, DEAD_CYC) and never wraps. Comparisons are exact equality.

Test Plan (bench params DEB_CYC=3, TRAVEL_MAX=20, DEAD_CYC=2):
- Homing: pulse R, LIM_DN=1 held -> MOT_DN=1 from the first cycle after R; CLOSED (POS=00, motors 0) 2 sync + 3 debounce cycles after R deasserts.
- Open/close cycle: from CLOSED, TAL=01 -> MOT_UP=1 next cycle. Raise LIM_UP -> OPEN 5 cycles later. TAL=11 -> 2 cycles with motors 0, then MOT_DN=1. Raise LIM_DN -> CLOSED.
- Obstacle reversal: in CLOSING, OBS=1 for 3+ cycles -> MOT_DN drops, 2 dead cycles with both motors 0, then MOT_UP=1. Never an overlap cycle.
- Obstacle hold: in OPEN with OBS=1, apply TAL=00 -> stays OPEN with motors 0. Release OBS -> dead time, then CLOSING.
- Timeout: TAL=01 with LIM_UP held 0 -> FAULT=1 after 20 cycles of MOT_UP=1. TAL toggling keeps FAULT. R clears it and re-homes.
- Glitch rejection and bad sensors: a 2-cycle LIM_DN pulse during CLOSING is ignored. LIM_UP=LIM_DN=1 held -> FAULT.
